// File: rtl/rdn_pkg.sv
// Shared types and constants for the RDN weight-load memory path.
package rdn_pkg;

    localparam int RDN_WORD_W     = 16;
    localparam int RDN_LINE_WORDS = 32;

    typedef logic [RDN_WORD_W-1:0] rdn_line_t [RDN_LINE_WORDS];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2,
        HOLD  = 2'd3
    } rdn_mem_state_t;

endpackage

// File: rtl/rdn_line_fifo.sv
// Line-wide synchronous FIFO with flush; DEPTH must be a power of 2 (>= 2).
module rdn_line_fifo #(
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 32,
    parameter int DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data [LINE_WORDS],
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] head_data [LINE_WORDS]
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH][LINE_WORDS];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                mem[wr_ptr_reg][w] <= push_data[w];
            end
        end
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_head
        assign head_data[gi] = mem[rd_ptr_reg][gi];
    end

endmodule

// File: rtl/rdn_weight_mem_responder.sv
// Serves buffered weight lines to the RDN loader, one line per request,
// and tracks image progress and protocol violations.
module rdn_weight_mem_responder
    import rdn_pkg::*;
#(
    parameter int WORD_W     = RDN_WORD_W,
    parameter int LINE_WORDS = RDN_LINE_WORDS,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           wr_en,
    input  logic [WORD_W-1:0]              wr_data [LINE_WORDS],
    output logic                           fifo_full,
    input  logic                           req_mem,
    output logic                           mem_ready,
    output logic [WORD_W-1:0]              mem_data [LINE_WORDS],
    output logic [$clog2(NUM_LINES+1)-1:0] lines_served,
    output logic                           done,
    output logic                           overrun,
    output logic                           wr_drop
);

    localparam int LSW = $clog2(NUM_LINES+1);
    localparam logic [LSW-1:0] NUM_LINES_C = LSW'(NUM_LINES);

    rdn_mem_state_t    state_reg, state_next;
    logic              pop;
    logic              set_overrun;
    logic              fifo_empty;
    logic              push;
    logic [WORD_W-1:0] head_data    [LINE_WORDS];
    logic [WORD_W-1:0] mem_data_reg [LINE_WORDS];
    logic [LSW-1:0]    lines_served_reg;
    logic              overrun_reg;
    logic              wr_drop_reg;

    // start discards any host write in the same cycle.
    assign push = wr_en && !start;

    rdn_line_fifo #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        set_overrun = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_mem) begin
                    if (done) begin
                        set_overrun = 1'b1;
                        state_next  = HOLD;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            // A request dropped here is still honoured once data arrives.
            FETCH: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = HOLD;
            HOLD:    if (!req_mem) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start) begin
            state_next  = IDLE;
            pop         = 1'b0;
            set_overrun = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_served_reg <= '0;
            overrun_reg      <= 1'b0;
            wr_drop_reg      <= 1'b0;
        end else if (start) begin
            lines_served_reg <= '0;
            overrun_reg      <= 1'b0;
            wr_drop_reg      <= 1'b0;
        end else begin
            if (state_reg == RESP && lines_served_reg != NUM_LINES_C)
                lines_served_reg <= lines_served_reg + 1'b1;
            if (set_overrun)
                overrun_reg <= 1'b1;
            if (wr_en && fifo_full && !pop)
                wr_drop_reg <= 1'b1;
        end
    end

    // Response line register: only a pop changes it, start leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < LINE_WORDS; w++) mem_data_reg[w] <= '0;
        end else if (pop) begin
            for (int w = 0; w < LINE_WORDS; w++) mem_data_reg[w] <= head_data[w];
        end
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_out
        assign mem_data[gi] = mem_data_reg[gi];
    end

    assign mem_ready    = (state_reg == RESP);
    assign lines_served = lines_served_reg;
    assign done         = (lines_served_reg == NUM_LINES_C);
    assign overrun      = overrun_reg;
    assign wr_drop      = wr_drop_reg;

endmodule

// File: tb/tb_rdn_weight_mem_responder.sv
// Directed bench for rdn_weight_mem_responder with hand-computed expectations.
module tb_rdn_weight_mem_responder;

    localparam int WORD_W     = 16;
    localparam int LINE_WORDS = 32;
    localparam int NUM_LINES  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data [LINE_WORDS];
    logic              fifo_full;
    logic              req_mem;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_data [LINE_WORDS];
    logic [6:0]        lines_served;
    logic              done;
    logic              overrun;
    logic              wr_drop;

    int n_tests = 0;
    int n_fail  = 0;

    rdn_weight_mem_responder #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .FIFO_DEPTH (4),
        .NUM_LINES  (NUM_LINES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .req_mem      (req_mem),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .lines_served (lines_served),
        .done         (done),
        .overrun      (overrun),
        .wr_drop      (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input logic [WORD_W-1:0] val);
        for (int w = 0; w < LINE_WORDS; w++) wr_data[w] = val + WORD_W'(w);
    endtask

    task automatic push_line(input logic [WORD_W-1:0] val);
        set_line(val);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    // One request; exp_lat > 0 also checks cycles from request to mem_ready.
    task automatic serve(input logic [WORD_W-1:0] exp_word, input int exp_lat);
        int lat = 0;
        logic got = 1'b0;
        req_mem = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if (mem_ready) got = 1'b1;
        end
        check("ready_seen", 32'(got), 32'd1);
        if (got) begin
            check("mem_data0", 32'(mem_data[0]), 32'(exp_word));
            check("mem_data31", 32'(mem_data[31]), 32'(exp_word + 16'd31));
            if (exp_lat > 0) check("ready_latency", 32'(lat), 32'(exp_lat));
        end
        req_mem = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int cnt;
        int pulse_cyc;
        logic got;
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; req_mem = 1'b0;
        set_line('0);
        tick();
        tick();
        check("rst_mem_ready", 32'(mem_ready), 0);
        check("rst_mem_data0", 32'(mem_data[0]), 0);
        check("rst_lines_served", 32'(lines_served), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fifo_full", 32'(fifo_full), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_wr_drop", 32'(wr_drop), 0);
        rst = 1'b0;
        tick();

        // Four lines, four requests, in order
        for (int i = 1; i <= 4; i++) push_line(WORD_W'(i));
        check("four_full", 32'(fifo_full), 1);
        for (int i = 1; i <= 4; i++) serve(WORD_W'(i), 1);
        check("four_served", 32'(lines_served), 4);

        // Held request on empty FIFO, one line pushed at cycle 5
        cnt = 0; pulse_cyc = -1;
        req_mem = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin set_line(16'h0040); wr_en = 1'b1; end
            tick();
            wr_en = 1'b0;
            if (mem_ready) begin cnt++; pulse_cyc = c + 1; end
        end
        check("held_pulses", 32'(cnt), 1);
        check("held_pulse_cycle", 32'(pulse_cyc), 7);
        check("held_data0", 32'(mem_data[0]), 32'h40);
        req_mem = 1'b0;
        tick();
        tick();
        check("held_served", 32'(lines_served), 5);

        // Overflow: fifth push is dropped
        for (int i = 11; i <= 14; i++) push_line(WORD_W'(i));
        check("ovf_full", 32'(fifo_full), 1);
        check("ovf_no_drop_yet", 32'(wr_drop), 0);
        push_line(16'd15);
        check("ovf_drop", 32'(wr_drop), 1);
        check("ovf_still_full", 32'(fifo_full), 1);
        for (int i = 11; i <= 14; i++) serve(WORD_W'(i), 1);
        check("ovf_drained", 32'(fifo_full), 0);
        check("ovf_served", 32'(lines_served), 9);

        // Push and pop in the same cycle while full
        start = 1'b1; tick(); start = 1'b0;
        check("start_clr_drop", 32'(wr_drop), 0);
        check("start_clr_served", 32'(lines_served), 0);
        for (int i = 21; i <= 24; i++) push_line(WORD_W'(i));
        check("pp_full_before", 32'(fifo_full), 1);
        set_line(16'd25);
        wr_en = 1'b1; req_mem = 1'b1;
        tick();
        wr_en = 1'b0;
        check("pp_ready", 32'(mem_ready), 1);
        check("pp_data0", 32'(mem_data[0]), 21);
        check("pp_full_after", 32'(fifo_full), 1);
        check("pp_wr_drop", 32'(wr_drop), 0);
        req_mem = 1'b0;
        tick();
        tick();
        for (int i = 22; i <= 25; i++) serve(WORD_W'(i), 1);
        check("pp_served", 32'(lines_served), 5);

        // Full image, then overrun
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            push_line(WORD_W'(100 + i));
            serve(WORD_W'(100 + i), 1);
            if (i == NUM_LINES - 2) check("done_before_last", 32'(done), 0);
        end
        check("img_served", 32'(lines_served), 64);
        check("img_done", 32'(done), 1);
        push_line(16'd200);
        cnt = 0;
        req_mem = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_ready) cnt++;
        end
        check("ovr_no_ready", 32'(cnt), 0);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_served_sat", 32'(lines_served), 64);
        req_mem = 1'b0;
        tick();
        tick();

        // start with a simultaneous write: write discarded, FIFO flushed
        set_line(16'd99);
        start = 1'b1; wr_en = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        check("st_overrun", 32'(overrun), 0);
        check("st_served", 32'(lines_served), 0);
        check("st_done", 32'(done), 0);
        check("st_keep_data", 32'(mem_data[0]), 163);
        cnt = 0;
        req_mem = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (mem_ready) cnt++;
        end
        check("st_fifo_empty", 32'(cnt), 0);
        push_line(16'd77);
        got = 1'b0;
        for (int c = 0; c < 5 && !got; c++) begin
            if (mem_ready) got = 1'b1;
            else tick();
        end
        check("st_late_ready", 32'(got), 1);
        check("st_late_data", 32'(mem_data[0]), 77);
        req_mem = 1'b0;
        tick();
        tick();

        // Reset during FETCH with a line just arrived
        req_mem = 1'b1;
        tick();
        push_line(16'd55);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(mem_ready), 0);
        check("mid_rst_data0", 32'(mem_data[0]), 0);
        check("mid_rst_served", 32'(lines_served), 0);
        check("mid_rst_full", 32'(fifo_full), 0);
        tick();
        req_mem = 1'b0;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_ready) cnt++;
        end
        check("mid_rst_no_ready", 32'(cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rdn_weight_mem_responder.md
# rdn_weight_mem_responder

Memory-side responder for the RDN weight-load protocol. It buffers 32-word weight lines pushed by the host-side DMA and serves them, one line per request, to the RDN weight loader over the `req_mem` / `mem_ready` / `mem_data` interface. It counts lines served against the weight-image size and flags protocol violations. It sits between the host memory interface and `rdn`.

## Interface

**Parameters**
- `WORD_W`, 16: width of one weight word.
- `LINE_WORDS`, 32: words per line.
- `FIFO_DEPTH`, 4: line buffer depth; must be a power of 2.
- `NUM_LINES`, 64: lines in one full weight image.

**Ports**
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: one-cycle pulse; begins a new image, flushes the FIFO, clears counters and flags.
- `wr_en`, in, 1: host pushes one line.
- `wr_data`, in, `[WORD_W-1:0] x [LINE_WORDS-1:0]`: host line data.
- `fifo_full`, out, 1: FIFO is at `FIFO_DEPTH` entries.
- `req_mem`, in, 1: level request from the weight loader.
- `mem_ready`, out, 1: one-cycle pulse; `mem_data` is valid.
- `mem_data`, out, `[WORD_W-1:0] x [LINE_WORDS-1:0]`: served line.
- `lines_served`, out, `$clog2(NUM_LINES+1)`: count of lines delivered.
- `done`, out, 1: `lines_served == NUM_LINES`.
- `overrun`, out, 1: sticky; a request arrived after `done`.
- `wr_drop`, out, 1: sticky; a host write arrived while full and no pop occurred that cycle.

## Operation

**Reset values.** All outputs are 0, `mem_data` is all-zero, the state is IDLE and the FIFO is empty.

**FSM states**
- **IDLE**
  - `req_mem`=1 and `done` → HOLD; `overrun` is set and no response is issued.
  - `req_mem`=1 and FIFO non-empty → RESP, popping the head into the `mem_data` register.
  - `req_mem`=1 and FIFO empty → FETCH.
- **FETCH**: when the FIFO is non-empty, pop → RESP.
- **RESP**: `mem_ready`=1 for exactly this cycle; `lines_served` increments; → HOLD.
- **HOLD**: wait until `req_mem` is sampled 0, then → IDLE. This guarantees exactly one line per request and prevents a held request from draining several lines.

**Data and counters**
- `mem_data` holds its value until the next pop. It is not cleared by `start`.
- `start` from any state:
  - returns the FSM to IDLE and empties the FIFO;
  - zeroes `lines_served`, `overrun` and `wr_drop`.
  - `start` has priority over all other events in the same cycle, including a `wr_en` in that cycle, which is discarded.
- `req_mem` dropping while in FETCH does not abort; the line is still delivered, then the FSM goes HOLD → IDLE.
- FIFO push and pop in the same cycle are both honoured, including when the FIFO is full.
- A write while full with no pop that cycle is discarded and sets `wr_drop`.
- `done` is combinational from `lines_served`. The counter saturates at `NUM_LINES`.

## Timing

- A request sampled in IDLE with the FIFO non-empty at edge t gives `mem_ready`=1 in cycle t+1, with `mem_data` valid in the same cycle.
- A line written at edge k becomes visible in cycle k+1. From FETCH, the pop occurs at edge k+1 and `mem_ready`=1 in cycle k+2.
- Minimum request-to-request spacing: RESP, then HOLD with `req_mem` low for at least one cycle, then a new request. This gives at most one line every 3 cycles.
- `fifo_full` and `lines_served` update on the edge following the push/pop.
- `rst` asserted mid-transfer clears everything immediately and asynchronously; no partial `mem_ready` pulse is produced.

## Structure

- **Package `rdn_pkg`** holds:
  - `RDN_WORD_W` and `RDN_LINE_WORDS` constants;
  - the `rdn_line_t` typedef (unpacked line array);
  - the `rdn_mem_state_t` enum {IDLE, FETCH, RESP, HOLD}.
- **Sub-module `rdn_line_fifo`**: synchronous FIFO with flush, using a power-of-2 pointer wrap. Ports: push, pop, flush, `full`, `empty`, head data.
- The FSM, counters and sticky flags live in the top module.

## Test plan

- **Reset, then 4 lines, 4 requests.** After reset, push 4 lines with word[0]=1..4, then issue 4 requests, each dropped after `mem_ready`. Expect `mem_data[0]` = 1, 2, 3, 4 and `lines_served`=4. Each `mem_ready` comes 1 cycle after the request is sampled.
- **Held request, empty FIFO.** Hold `req_mem` high for 10 cycles, then push one line at cycle 5. Expect exactly one `mem_ready` at cycle 7, and no second pulse while the request stays high.
- **Overflow.** Push 5 lines with no pops. Expect `fifo_full`=1 after 4 pushes, `wr_drop`=1, and only 4 lines served afterward.
- **Push and pop when full.** FIFO full, push and pop in the same cycle. Expect `fifo_full` to stay 1, `wr_drop`=0, and data order preserved.
- **Image end and overrun.** `NUM_LINES`=64: serve 64 lines, expect `done`=1. Issue a 65th request: expect no `mem_ready` and `overrun`=1. Then `start`: expect `overrun`=0, `lines_served`=0, FIFO empty.
- **Reset mid-transfer.** Assert `rst` in cycle FETCH+1 while the request is pending. Expect all outputs 0 immediately and no `mem_ready` afterward until a new request.
